if_stage: RTL

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues word reads to instruction memory over a ready/valid handshake. Returned words go into a small fetch buffer, and the head of that buffer is presented to the IF/ID boundary. It obeys the decode stage's hazard freeze and redirects on a taken branch, discarding any stale in-flight response.

---
 rtl/if_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/if_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and default widths for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned PC_LEN_DEF    = 24;
    localparam int unsigned WORD_LEN_DEF  = 16;
    localparam int unsigned BUF_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_LEN_DEF-1:0]   pc;
        logic [WORD_LEN_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, inst} entries; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, one-outstanding imem handshake, fetch buffer, branch redirect.
// Optional IF_PERF_CNT_EN adds a saturating bubble_cnt output.
module if_stage
    import if_pkg::*;
#(
    parameter int unsigned PC_LEN    = PC_LEN_DEF,
    parameter int unsigned WORD_LEN  = WORD_LEN_DEF,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                brTaken,
    input  logic [PC_LEN-1:0]   br_target,
    output logic                imem_req,
    output logic [PC_LEN-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic                imem_valid,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic                inst_valid,
    output logic [WORD_LEN-1:0] instruction,
    output logic [PC_LEN-1:0]   pc_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]         bubble_cnt
`endif
);

    localparam int unsigned ENTRY_W = PC_LEN + WORD_LEN;
    localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;

    fetch_state_t        state_q, state_d;
    logic [PC_LEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_LEN-1:0]   req_pc_q;
    logic [CNT_W-1:0]    buf_count;
    logic                buf_empty, buf_full;
    logic                buf_push_req, buf_push, buf_pop, buf_flush;
    logic [ENTRY_W-1:0]  buf_wdata, buf_rdata;
    logic                outstanding, space, accept, br_take;

    assign inst_valid  = !buf_empty;
    assign instruction = buf_rdata[WORD_LEN-1:0];
    assign pc_out      = buf_rdata[ENTRY_W-1:WORD_LEN];
    assign imem_addr   = fetch_pc_q;

    // A branch only counts when it resolves against a real head instruction.
    assign br_take     = brTaken && inst_valid;
    assign buf_pop     = inst_valid && !freeze;
    assign buf_flush   = br_take;
    assign outstanding = (state_q == WAIT);

    // Reserve a slot for the in-flight word so a response can never hit a full buffer.
    assign space = (int'(buf_count) + int'(outstanding) - int'(buf_pop)) < int'(BUF_DEPTH);

    assign imem_req = ((state_q == FETCH) || ((state_q == WAIT) && imem_valid))
                      && space && !brTaken && !rst;
    assign accept   = imem_req && imem_ready;

    assign buf_push_req = outstanding && imem_valid && !br_take;
    assign buf_push     = buf_push_req && !buf_full;
    assign buf_wdata    = {req_pc_q, imem_rdata};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (buf_flush),
        .wdata (buf_wdata),
        .rdata (buf_rdata),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;

        if (br_take) begin
            fetch_pc_d = br_target;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end

        unique case (state_q)
            FETCH: begin
                if (accept) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (br_take) begin
                    state_d = imem_valid ? FETCH : DRAIN;
                end else if (imem_valid) begin
                    state_d = accept ? WAIT : FETCH;
                end
            end
            DRAIN: begin
                if (imem_valid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= '0;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (accept) begin
                req_pc_q <= fetch_pc_q;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [15:0] bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
        end else if (!inst_valid && (bubble_q != 16'hFFFF)) begin
            bubble_q <= bubble_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_q;
`endif

endmodule
